thinpad_sram_sched: RTL and testbench

THINPAD_SRAM_SCHED -- requirements
Module: thinpad_sram_sched

---
 rtl/thinpad_sram_sched_pkg.sv | 18 +
 rtl/thinpad_sram_sched.sv | 114 +++++++++++
 tb/tb_thinpad_sram_sched.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/thinpad_sram_sched_pkg.sv
// Shared types and constants for the thinpad SRAM burst scheduler.
package thinpad_sram_sched_pkg;

    localparam int unsigned TURN_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StTurn,
        StWr,
        StRd
    } state_t;

    typedef enum logic {
        DirWrite,
        DirRead
    } dir_t;

endpackage

// File: rtl/thinpad_sram_sched.sv
// Write/read burst scheduler for a shared SRAM, with bus turnaround on direction change.
// Optional macro THINPAD_SRAM_SCHED_RR_EN: round-robin on simultaneous requests (else read wins).
module thinpad_sram_sched
    import thinpad_sram_sched_pkg::*;
#(
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned TURNAROUND = 1
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             wr_req,
    input  logic [LEN_W-1:0] wr_len,
    input  logic             rd_req,
    input  logic [LEN_W-1:0] rd_len,
    input  logic             beat,
    output logic             wr_gnt,
    output logic             rd_gnt,
    output logic             sram_we,
    output logic             sram_oe,
    output logic             last,
    output logic             busy
);

    state_t            r_state, w_state_nxt;
    logic [LEN_W-1:0]  r_cnt, w_cnt_nxt;
    logic [TURN_W-1:0] r_turn, w_turn_nxt;
    dir_t              r_sel_dir, w_sel_dir_nxt;
    dir_t              r_last_dir, w_last_dir_nxt;
    dir_t              w_pick;
    logic              w_any_req;
    logic              w_same_dir;

    assign w_any_req = wr_req | rd_req;

    always_comb begin
        w_pick = DirWrite;
        if (wr_req && rd_req) begin
`ifdef THINPAD_SRAM_SCHED_RR_EN
            w_pick = (r_last_dir == DirWrite) ? DirRead : DirWrite;
`else
            w_pick = DirRead;
`endif
        end else if (rd_req) begin
            w_pick = DirRead;
        end
    end

    assign w_same_dir = (w_pick == r_last_dir) || (TURNAROUND == 0);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_turn_nxt     = r_turn;
        w_sel_dir_nxt  = r_sel_dir;
        w_last_dir_nxt = r_last_dir;
        unique case (r_state)
            StIdle: begin
                if (w_any_req) begin
                    w_sel_dir_nxt = w_pick;
                    w_cnt_nxt     = (w_pick == DirRead) ? rd_len : wr_len;
                    if (w_same_dir) begin
                        w_state_nxt = (w_pick == DirRead) ? StRd : StWr;
                    end else begin
                        // Turn counter counts down to zero, so TURN spans TURNAROUND cycles.
                        w_state_nxt = StTurn;
                        w_turn_nxt  = TURN_W'(TURNAROUND - 1);
                    end
                end
            end
            StTurn: begin
                if (r_turn == '0) begin
                    w_state_nxt = (r_sel_dir == DirRead) ? StRd : StWr;
                end else begin
                    w_turn_nxt = r_turn - 1'b1;
                end
            end
            StWr, StRd: begin
                if (beat) begin
                    if (r_cnt == '0) begin
                        w_last_dir_nxt = r_sel_dir;
                        w_state_nxt    = StIdle;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_turn     <= '0;
            r_sel_dir  <= DirWrite;
            r_last_dir <= DirWrite;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_turn     <= w_turn_nxt;
            r_sel_dir  <= w_sel_dir_nxt;
            r_last_dir <= w_last_dir_nxt;
        end
    end

    assign wr_gnt  = (r_state == StWr);
    assign rd_gnt  = (r_state == StRd);
    assign sram_we = wr_gnt;
    assign sram_oe = rd_gnt;
    assign last    = (wr_gnt | rd_gnt) & (r_cnt == '0);
    assign busy    = (r_state != StIdle);

endmodule

// File: tb/tb_thinpad_sram_sched.sv
// Self-checking bench for thinpad_sram_sched: directed table, hand sequences, random vs model.
module tb_thinpad_sram_sched;

    localparam int unsigned LEN_W      = 8;
    localparam int unsigned TURNAROUND = 1;

    logic             ACLK = 1'b0;
    logic             ARESETN;
    logic             wr_req, rd_req, beat;
    logic [LEN_W-1:0] wr_len, rd_len;
    logic             wr_gnt, rd_gnt, sram_we, sram_oe, last, busy;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [5:0] s_out;

    // Transaction-level model: dir 0 none / 1 write / 2 read; m_left is beats still owed.
    int m_dir  = 0;
    int m_wait = 0;
    int m_left = 0;
    int m_last = 1;
    int m_pend = 0;

    typedef struct {
        logic       rst_n;
        logic       wr_req;
        logic [7:0] wr_len;
        logic       rd_req;
        logic [7:0] rd_len;
        logic       beat;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl [16];

    thinpad_sram_sched #(
        .LEN_W      (LEN_W),
        .TURNAROUND (TURNAROUND)
    ) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .wr_req  (wr_req),
        .wr_len  (wr_len),
        .rd_req  (rd_req),
        .rd_len  (rd_len),
        .beat    (beat),
        .wr_gnt  (wr_gnt),
        .rd_gnt  (rd_gnt),
        .sram_we (sram_we),
        .sram_oe (sram_oe),
        .last    (last),
        .busy    (busy)
    );

    always #5 ACLK = ~ACLK;

    function automatic logic [5:0] model_out();
        logic g_w, g_r;
        g_w = (m_dir == 1);
        g_r = (m_dir == 2);
        return {g_w, g_r, g_w, g_r, (m_dir != 0) && (m_left == 1), (m_dir != 0) || (m_wait > 0)};
    endfunction

    task automatic model_step();
        int pick;
        if (!ARESETN) begin
            m_dir  = 0;
            m_wait = 0;
            m_left = 0;
            m_last = 1;
            m_pend = 0;
        end else if (m_dir == 0 && m_wait == 0) begin
            if (wr_req || rd_req) begin
                if (wr_req && rd_req) begin
`ifdef THINPAD_SRAM_SCHED_RR_EN
                    pick = (m_last == 1) ? 2 : 1;
`else
                    pick = 2;
`endif
                end else begin
                    pick = rd_req ? 2 : 1;
                end
                m_left = ((pick == 2) ? int'(rd_len) : int'(wr_len)) + 1;
                if (pick == m_last || TURNAROUND == 0) begin
                    m_dir = pick;
                end else begin
                    m_wait = TURNAROUND;
                    m_pend = pick;
                end
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) m_dir = m_pend;
        end else if (beat) begin
            m_left--;
            if (m_left == 0) begin
                m_last = m_dir;
                m_dir  = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // One clock: sample/check at negedge, then advance DUT and model on the rising edge.
    task automatic cyc(input string name, input bit use_exp, input logic [5:0] exp);
        @(negedge ACLK);
        s_out = {wr_gnt, rd_gnt, sram_we, sram_oe, last, busy};
        check({name, " model"}, s_out, model_out());
        if (use_exp) check({name, " table"}, s_out, exp);
        n_checks++;
        if (wr_gnt && rd_gnt) begin
            n_errors++;
            $display("FAIL excl %s: wr_gnt=%b rd_gnt=%b expected not both 1", name, wr_gnt, rd_gnt);
        end
        @(posedge ACLK);
        model_step();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] first_g, second_g;
        logic [5:0] ord_exp;
        logic [5:0] n_gnt;

        tbl[0]  = '{1'b1, 1'b1, 8'd7, 1'b0, 8'd0, 1'b1, 6'b000000};
        for (int i = 1; i < 8; i++) tbl[i] = '{1'b1, 1'b0, 8'd7, 1'b0, 8'd0, 1'b1, 6'b101001};
        tbl[8]  = '{1'b1, 1'b0, 8'd7, 1'b0, 8'd0, 1'b1, 6'b101011};
        tbl[9]  = '{1'b1, 1'b0, 8'd0, 1'b1, 8'd3, 1'b0, 6'b000000};
        tbl[10] = '{1'b1, 1'b0, 8'd0, 1'b1, 8'd3, 1'b1, 6'b000001};
        for (int i = 11; i < 14; i++) tbl[i] = '{1'b1, 1'b0, 8'd0, 1'b0, 8'd3, 1'b1, 6'b010101};
        tbl[14] = '{1'b1, 1'b0, 8'd0, 1'b0, 8'd3, 1'b1, 6'b010111};
        tbl[15] = '{1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 6'b000000};

        ARESETN = 1'b0;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        wr_len  = '0;
        rd_len  = '0;
        beat    = 1'b0;
        cyc("reset", 1'b0, 6'b0);
        cyc("reset", 1'b1, 6'b000000);

        // Write len=7 then read len=3 across one turnaround; beat pulsed in IDLE and TURN.
        for (int i = 0; i < 16; i++) begin
            ARESETN = tbl[i].rst_n;
            wr_req  = tbl[i].wr_req;
            wr_len  = tbl[i].wr_len;
            rd_req  = tbl[i].rd_req;
            rd_len  = tbl[i].rd_len;
            beat    = tbl[i].beat;
            cyc($sformatf("tbl%0d", i), 1'b1, tbl[i].exp);
        end

        // Simultaneous requests with last_dir = READ.
        wr_req   = 1'b1;
        wr_len   = 8'd1;
        rd_req   = 1'b1;
        rd_len   = 8'd1;
        beat     = 1'b1;
        first_g  = 2'd0;
        second_g = 2'd0;
        for (int i = 0; i < 20; i++) begin
            cyc("arb", 1'b0, 6'b0);
            if (s_out[5]) begin
                wr_req = 1'b0;
                if (first_g == 2'd0) first_g = 2'd1;
                else if (first_g != 2'd1 && second_g == 2'd0) second_g = 2'd1;
            end
            if (s_out[4]) begin
                rd_req = 1'b0;
                if (first_g == 2'd0) first_g = 2'd2;
                else if (first_g != 2'd2 && second_g == 2'd0) second_g = 2'd2;
            end
        end
`ifdef THINPAD_SRAM_SCHED_RR_EN
        ord_exp = {2'b00, 2'd1, 2'd2};
`else
        ord_exp = {2'b00, 2'd2, 2'd1};
`endif
        check("arb_order", {2'b00, first_g, second_g}, ord_exp);

        // Reset on the 3rd beat of a len=7 write, then a single-beat write.
        wr_req = 1'b1;
        wr_len = 8'd7;
        beat   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc("rst_wait", 1'b0, 6'b0);
            if (s_out[5]) break;
        end
        check("rst_first_beat", s_out, 6'b101001);
        wr_req = 1'b0;
        cyc("rst_beat2", 1'b1, 6'b101001);
        ARESETN = 1'b0;
        cyc("rst_beat3", 1'b1, 6'b101001);
        ARESETN = 1'b1;
        beat    = 1'b0;
        cyc("rst_mid", 1'b1, 6'b000000);
        wr_req = 1'b1;
        wr_len = 8'd0;
        cyc("len0_req", 1'b1, 6'b000000);
        wr_req = 1'b0;
        beat   = 1'b1;
        cyc("len0_gnt", 1'b1, 6'b101011);
        beat = 1'b0;
        cyc("len0_done", 1'b1, 6'b000000);

        // Request dropped and len changed mid-burst: burst keeps its latched length.
        wr_req = 1'b1;
        wr_len = 8'd2;
        beat   = 1'b1;
        cyc("latch_req", 1'b1, 6'b000000);
        wr_req = 1'b0;
        wr_len = 8'd9;
        n_gnt  = '0;
        for (int i = 0; i < 20; i++) begin
            cyc("latch_run", 1'b0, 6'b0);
            if (s_out[5]) n_gnt = n_gnt + 6'd1;
        end
        check("latch_len", n_gnt, 6'd3);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            ARESETN = ($urandom_range(0, 199) != 0);
            beat    = ($urandom_range(0, 3) != 0);
            if (!wr_req && $urandom_range(0, 3) == 0) begin
                wr_req = 1'b1;
                wr_len = LEN_W'($urandom_range(0, 5));
            end
            if (!rd_req && $urandom_range(0, 3) == 0) begin
                rd_req = 1'b1;
                rd_len = LEN_W'($urandom_range(0, 5));
            end
            cyc("rand", 1'b0, 6'b0);
            if (s_out[5]) begin
                wr_req = 1'b0;
                wr_len = LEN_W'($urandom);
            end
            if (s_out[4]) begin
                rd_req = 1'b0;
                rd_len = LEN_W'($urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
